// File: rtl/bt_uart_pkg.sv
// Shared UART constants and FSM state encoding for the Bluetooth serial link.
// Used by both the transmit and receive sides so the bit period agrees.
package bt_uart_pkg;

  localparam int BPS_NUM_DEFAULT = 10417;
  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } bt_state_t;

endpackage

// File: rtl/bt_tx_fifo.sv
// Small byte FIFO with async reset and a combinational head output.
// Pointers carry an extra wrap bit so full and empty fall out of a compare.
module bt_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         push;
  logic         pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/bluetooth_tx.sv
// UART transmitter (8N1, LSB first) with a byte FIFO for the phone link.
// Define BT_TX_PARITY_EN to insert an even-parity bit (8E1 framing).
module bluetooth_tx
  import bt_uart_pkg::*;
#(
  parameter int BPS_NUM    = BPS_NUM_DEFAULT,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 14
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_out,
  output logic                 busy,
  output logic                 tx_done
);

  bt_state_t            state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]     clk_cnt_q, clk_cnt_d;
  logic                 tx_q, tx_d;
  logic                 rdy_q;
  logic                 pop;
  logic                 bit_end;
  logic [DATA_BITS-1:0] head;
  logic                 fifo_full;
  logic                 fifo_empty;
`ifdef BT_TX_PARITY_EN
  logic                 par_q;
`endif

  bt_tx_fifo #(
    .DEPTH(FIFO_DEPTH),
    .W    (DATA_BITS)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (tx_valid && tx_ready),
    .wr_data(tx_data),
    .rd_en  (pop),
    .rd_data(head),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign bit_end  = (clk_cnt_q == CNT_W'(BPS_NUM - 1));
  assign tx_ready = rdy_q && !fifo_full;
  assign tx_out   = tx_q;
  assign busy     = (state_q != IDLE) || !fifo_empty;
  assign tx_done  = (state_q == STOP) && bit_end;

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    tx_d      = tx_q;
    pop       = 1'b0;
    clk_cnt_d = '0;
    if (state_q != IDLE && !bit_end)
      clk_cnt_d = clk_cnt_q + 1'b1;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          shift_d   = head;
          bit_cnt_d = '0;
          tx_d      = 1'b0;
          state_d   = START;
        end
      end
      START: begin
        if (bit_end) begin
          tx_d    = shift_q[0];
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d   = shift_q >> 1;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
`ifdef BT_TX_PARITY_EN
            tx_d    = par_q;
            state_d = PARITY;
`else
            tx_d    = 1'b1;
            state_d = STOP;
`endif
          end else begin
            tx_d = shift_q[1];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          tx_d    = 1'b1;
          state_d = STOP;
        end
      end
      STOP: begin
        // Back-to-back frames: reload in the stop cycle, no idle gap
        if (bit_end) begin
          if (!fifo_empty) begin
            pop       = 1'b1;
            shift_d   = head;
            bit_cnt_d = '0;
            tx_d      = 1'b0;
            state_d   = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      clk_cnt_q <= '0;
      tx_q      <= 1'b1;
      rdy_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      clk_cnt_q <= clk_cnt_d;
      tx_q      <= tx_d;
      rdy_q     <= 1'b1;
    end
  end

`ifdef BT_TX_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      par_q <= 1'b0;
    else if (pop) par_q <= ^head;
  end
`endif

endmodule

// File: tb/tb_bluetooth_tx.sv
// Bench for bluetooth_tx: directed steps, scoreboard of accepted bytes,
// serial-line monitor decoding frames at BPS_NUM=5.
module tb_bluetooth_tx;

  localparam int BPS = 5;
`ifdef BT_TX_PARITY_EN
  localparam int NBIT = 11;
`else
  localparam int NBIT = 10;
`endif
  localparam int FRAME = NBIT * BPS;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       tx_out;
  logic       busy;
  logic       tx_done;

  bluetooth_tx #(
    .BPS_NUM   (BPS),
    .FIFO_DEPTH(4),
    .CNT_W     (14)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx_out  (tx_out),
    .busy    (busy),
    .tx_done (tx_done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int n_exp = 0;
  logic [7:0] q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Serial-line monitor
  int         m_on = 0;
  int         m_t0 = 0;
  int         m_last = -1;
  int         m_contig = 0;
  int         m_frames = 0;
  int         dcnt = 0;
  logic [7:0] m_byte = 8'h00;
  logic       m_prev = 1'b1;

  always @(negedge clk) begin
    int off;
    int idx;
    logic [7:0] e;
    if (rst) begin
      m_on   = 0;
      m_prev = 1'b1;
    end else begin
      if (tx_done) dcnt++;
      if (m_on == 0 && m_prev && !tx_out) begin
        m_on = 1;
        m_t0 = cyc;
        if (cyc == m_last) m_contig++;
      end
      if (m_on != 0) begin
        off = cyc - m_t0;
        idx = off / BPS;
        if (off % BPS == 2) begin
          if (idx == 0) begin
            chk("start_bit", tx_out, 0);
          end else if (idx <= 8) begin
            m_byte[idx-1] = tx_out;
          end else if (idx == NBIT - 1) begin
            chk("stop_bit", tx_out, 1);
            if (q.size() == 0) begin
              tests++;
              fails++;
              $error("FAIL unexpected_frame: got %0h want none", m_byte);
            end else begin
              e = q.pop_front();
              chk("rx_byte", m_byte, e);
            end
          end
`ifdef BT_TX_PARITY_EN
          else if (idx == 9 && q.size() > 0) begin
            chk("parity_bit", tx_out, ^q[0]);
          end
`endif
        end
        if (off == FRAME - 1) begin
          chk("done_time", tx_done, 1);
          m_on = 0;
          m_last = cyc + 1;
          m_frames++;
        end
      end
      m_prev = tx_out;
    end
  end

  task automatic put(input logic [7:0] b);
    bit ok = 0;
    tx_valid = 1'b1;
    tx_data  = b;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (tx_ready) begin
        ok = 1;
        q.push_back(b);
        n_exp++;
      end
      @(negedge clk);
    end
    if (!ok) begin
      tests++;
      fails++;
      $error("FAIL put_timeout: got no accept want %0h", b);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 3000; i++) begin
      if (!busy && m_on == 0 && tx_out) break;
      @(negedge clk);
    end
    chk("idle_reached", busy, 0);
    chk("q_drained", q.size(), 0);
  endtask

  initial begin
    int e;
    int c0;
    bit hi_bad;

    repeat (3) @(negedge clk);
    chk("rst_tx_out", tx_out, 1);
    chk("rst_ready", tx_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", tx_done, 0);
    rst = 1'b0;
    #1 chk("ready_before_edge", tx_ready, 0);
    @(negedge clk);
    chk("ready_after_edge", tx_ready, 1);

    // Single byte into an idle block
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    q.push_back(8'hA5);
    n_exp++;
    @(negedge clk);
    e = cyc;
    tx_valid = 1'b0;
    chk("line_high_at_E", tx_out, 1);
    chk("busy_at_E", busy, 1);
    @(negedge clk);
    chk("start_low_E1", tx_out, 0);
    while (cyc < e + 50) @(negedge clk);
    chk("done_E50", tx_done, 1);
    chk("busy_E50", busy, 1);
    @(negedge clk);
    chk("done_E51", tx_done, 0);
    chk("busy_E51", busy, 0);
    chk("line_idle_E51", tx_out, 1);

    // Burst with tx_valid held, then a pulse while full
    c0 = m_contig;
    put(8'h01);
    put(8'h02);
    put(8'h03);
    put(8'h04);
    put(8'h05);
    chk("ready_full", tx_ready, 0);
    tx_data = 8'hEE;
    @(negedge clk);
    chk("ready_still_full", tx_ready, 0);
    tx_valid = 1'b0;
    wait_idle();
    chk("burst_contig", m_contig - c0, 4);

    // Push and pop in the same cycle with three entries queued
    put(8'h10);
    put(8'h20);
    put(8'h30);
    put(8'h40);
    tx_valid = 1'b0;
    for (int i = 0; i < 200 && !tx_done; i++) @(negedge clk);
    chk("pp_done_seen", tx_done, 1);
    tx_data  = 8'h50;
    tx_valid = 1'b1;
    chk("pp_ready_at3", tx_ready, 1);
    q.push_back(8'h50);
    n_exp++;
    @(negedge clk);
    tx_valid = 1'b0;
    chk("pp_ready_after", tx_ready, 1);
    wait_idle();

    // Reset during data bit 3 of 0xFF, with a second byte queued
    put(8'hFF);
    e = cyc;
    put(8'h11);
    tx_valid = 1'b0;
    while (cyc < e + 23) @(negedge clk);
    chk("pre_rst_bit", tx_out, 1);
    rst = 1'b1;
    #1;
    chk("rst_mid_tx_out", tx_out, 1);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_ready", tx_ready, 0);
    n_exp -= q.size();
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    hi_bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx_out !== 1'b1) hi_bad = 1;
    end
    chk("line_stays_high", hi_bad, 0);
    chk("no_busy_after_rst", busy, 0);
    put(8'h3C);
    tx_valid = 1'b0;
    wait_idle();

    // Parity-sensitive bytes (odd and even weight)
    put(8'h07);
    tx_valid = 1'b0;
    wait_idle();
    put(8'h03);
    tx_valid = 1'b0;
    wait_idle();

    chk("done_pulses", dcnt, n_exp);
    chk("frames", m_frames, n_exp);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
